reg_writeback_unit: RTL and testbench

Write-side driver of the integer/floating register file. It merges two result sources into the single register-file write port (reg_we, reg_we_opcode, reg_w_addr, reg_w_data):
- in-order ALU/FPU results from the MEM stage;
- out-of-order-in-time load data returning from the AXI data read channel.

It tracks outstanding loads in a tag FIFO, extracts and sign- or zero-extends load data, and reports RAW hazards against pending loads to the decode stage.

---
 rtl/reg_writeback_unit.sv | 172 +++++++++++++++++
 tb/tb_reg_writeback_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_unit.sv
// Register-file write-port driver. Merges in-order ex results and returning
// load data into one registered write port, tracks outstanding loads in a
// tag FIFO, and extends load data by size/sign.
// Build option: define WB_SCOREBOARD_EN to generate the RAW hazard flags;
// when undefined, hazard_rs1/hazard_rs2 are tied low.
module reg_writeback_unit #(
   parameter int LD_DEPTH = 2,
   parameter int LD_PTR_W = $clog2(LD_DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        AXI_stall,
   input  logic        ex_valid,
   input  logic [6:0]  ex_opcode,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_data,
   output logic        ex_ready,
   input  logic        ld_issue_valid,
   output logic        ld_issue_ready,
   input  logic [6:0]  ld_issue_opcode,
   input  logic [2:0]  ld_issue_funct3,
   input  logic [4:0]  ld_issue_rd,
   input  logic [1:0]  ld_issue_addr_lo,
   input  logic        ld_rvalid,
   input  logic [31:0] ld_rdata,
   output logic        ld_rready,
   input  logic [4:0]  chk_rs1,
   input  logic [4:0]  chk_rs2,
   input  logic        chk_rs1_fp,
   input  logic        chk_rs2_fp,
   output logic        hazard_rs1,
   output logic        hazard_rs2,
   output logic        reg_we,
   output logic [6:0]  reg_we_opcode,
   output logic [4:0]  reg_w_addr,
   output logic [31:0] reg_w_data
);

   localparam logic [6:0] OP_FLW    = 7'b0000111;
   localparam logic [6:0] OP_F_TYPE = 7'b1010011;
   localparam logic [LD_PTR_W:0] DEPTH_CNT = (LD_PTR_W+1)'(LD_DEPTH);

   logic [6:0]          fifo_op     [LD_DEPTH];
   logic [2:0]          fifo_funct3 [LD_DEPTH];
   logic [4:0]          fifo_rd     [LD_DEPTH];
   logic [1:0]          fifo_addr   [LD_DEPTH];
   logic [LD_PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LD_PTR_W:0]   count;

   logic        advance, push, pop, fifo_empty;
   logic [31:0] ld_value;

   function automatic logic is_fp(input logic [6:0] op);
      return (op == OP_F_TYPE) || (op == OP_FLW);
   endfunction

   // Integer x0 is hardwired zero, so such results occupy a slot but never write.
   function automatic logic writes_reg(input logic [6:0] op, input logic [4:0] rd);
      return !((rd == 5'd0) && !is_fp(op));
   endfunction

   assign advance        = !AXI_stall;
   assign fifo_empty     = (count == '0);
   assign ld_issue_ready = !rst && (count != DEPTH_CNT);
   assign push           = ld_issue_valid && ld_issue_ready;
   assign ex_ready       = !rst && advance && ex_valid;
   assign pop            = !rst && advance && !ex_valid && ld_rvalid && !fifo_empty;
   assign ld_rready      = pop;

   // Size/sign extraction of the word returned for the load at the FIFO head.
   always_comb begin
      logic [31:0] shifted;
      logic [15:0] half;
      logic [2:0]  f3;
      logic [1:0]  a_lo;
      f3      = fifo_funct3[rd_ptr];
      a_lo    = fifo_addr[rd_ptr];
      shifted = ld_rdata >> {a_lo, 3'b000};
      half    = a_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
      ld_value = ld_rdata;
      if (fifo_op[rd_ptr] != OP_FLW) begin
         case (f3)
            3'b000:  ld_value = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ld_value = {24'd0, shifted[7:0]};
            3'b001:  ld_value = {{16{half[15]}}, half};
            3'b101:  ld_value = {16'd0, half};
            default: ld_value = ld_rdata;
         endcase
      end
   end

   // Tag storage; contents are only meaningful between rd_ptr and wr_ptr.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr]     <= ld_issue_opcode;
         fifo_funct3[wr_ptr] <= ld_issue_funct3;
         fifo_rd[wr_ptr]     <= ld_issue_rd;
         fifo_addr[wr_ptr]   <= ld_issue_addr_lo;
      end
   end

   // Tag FIFO pointers and occupancy; pointers wrap naturally at LD_DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Output stage: ex has priority over load return; holds while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_we        <= 1'b0;
         reg_we_opcode <= '0;
         reg_w_addr    <= '0;
         reg_w_data    <= '0;
      end else if (advance) begin
         if (ex_valid) begin
            reg_we        <= writes_reg(ex_opcode, ex_rd);
            reg_we_opcode <= ex_opcode;
            reg_w_addr    <= ex_rd;
            reg_w_data    <= ex_data;
         end else if (pop) begin
            reg_we        <= writes_reg(fifo_op[rd_ptr], fifo_rd[rd_ptr]);
            reg_we_opcode <= fifo_op[rd_ptr];
            reg_w_addr    <= fifo_rd[rd_ptr];
            reg_w_data    <= ld_value;
         end else begin
            reg_we <= 1'b0;
         end
      end
   end

`ifdef WB_SCOREBOARD_EN
   function automatic logic src_match(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic rs_fp);
      return (rd == rs) && (is_fp(op) == rs_fp) && !((rs == 5'd0) && !rs_fp);
   endfunction

   // RAW check against every pending load tag and the occupied output stage.
   always_comb begin
      logic [LD_PTR_W-1:0] off;
      hazard_rs1 = 1'b0;
      hazard_rs2 = 1'b0;
      off        = '0;
      for (int i = 0; i < LD_DEPTH; i++) begin
         off = LD_PTR_W'(i) - rd_ptr;
         if ({1'b0, off} < count) begin
            if (src_match(fifo_op[i], fifo_rd[i], chk_rs1, chk_rs1_fp)) hazard_rs1 = 1'b1;
            if (src_match(fifo_op[i], fifo_rd[i], chk_rs2, chk_rs2_fp)) hazard_rs2 = 1'b1;
         end
      end
      if (reg_we && src_match(reg_we_opcode, reg_w_addr, chk_rs1, chk_rs1_fp)) hazard_rs1 = 1'b1;
      if (reg_we && src_match(reg_we_opcode, reg_w_addr, chk_rs2, chk_rs2_fp)) hazard_rs2 = 1'b1;
   end
`else
   logic unused_chk;
   assign unused_chk = ^{chk_rs1, chk_rs2, chk_rs1_fp, chk_rs2_fp};
   assign hazard_rs1 = 1'b0;
   assign hazard_rs2 = 1'b0;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Scoreboard bench for reg_writeback_unit: stimulus pushes expected commits,
// a monitor pops them whenever the register file would commit a write.
module tb_reg_writeback_unit;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_FLW  = 7'b0000111;
`ifdef WB_SCOREBOARD_EN
   localparam logic SB_EN = 1'b1;
`else
   localparam logic SB_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        AXI_stall;
   logic        ex_valid;
   logic [6:0]  ex_opcode;
   logic [4:0]  ex_rd;
   logic [31:0] ex_data;
   logic        ex_ready;
   logic        ld_issue_valid;
   logic        ld_issue_ready;
   logic [6:0]  ld_issue_opcode;
   logic [2:0]  ld_issue_funct3;
   logic [4:0]  ld_issue_rd;
   logic [1:0]  ld_issue_addr_lo;
   logic        ld_rvalid;
   logic [31:0] ld_rdata;
   logic        ld_rready;
   logic [4:0]  chk_rs1, chk_rs2;
   logic        chk_rs1_fp, chk_rs2_fp;
   logic        hazard_rs1, hazard_rs2;
   logic        reg_we;
   logic [6:0]  reg_we_opcode;
   logic [4:0]  reg_w_addr;
   logic [31:0] reg_w_data;

   typedef struct {
      logic [4:0]  addr;
      logic [6:0]  op;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   reg_writeback_unit #(.LD_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .AXI_stall(AXI_stall),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_data(ex_data),
      .ex_ready(ex_ready),
      .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready),
      .ld_issue_opcode(ld_issue_opcode), .ld_issue_funct3(ld_issue_funct3),
      .ld_issue_rd(ld_issue_rd), .ld_issue_addr_lo(ld_issue_addr_lo),
      .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_rready(ld_rready),
      .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rs1_fp(chk_rs1_fp), .chk_rs2_fp(chk_rs2_fp),
      .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
      .reg_we(reg_we), .reg_we_opcode(reg_we_opcode), .reg_w_addr(reg_w_addr),
      .reg_w_data(reg_w_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [6:0] op, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.op   = op;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [1:0] a_lo);
      ld_issue_valid   = 1'b1;
      ld_issue_opcode  = op;
      ld_issue_funct3  = f3;
      ld_issue_rd      = rd;
      ld_issue_addr_lo = a_lo;
   endtask

   task automatic clear_inputs();
      ex_valid = 1'b0; ld_issue_valid = 1'b0; ld_rvalid = 1'b0; AXI_stall = 1'b0;
   endtask

   // Monitor: a write commits when reg_we is high in a cycle with AXI_stall low.
   always @(negedge clk) begin
      if (!rst && reg_we && !AXI_stall) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write",
                     reg_w_addr, reg_w_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(reg_w_addr), 32'(e.addr));
            chk("wr_opcode", 32'(reg_we_opcode), 32'(e.op));
            chk("wr_data", reg_w_data, e.data);
         end
      end
   end

   initial begin
      rst = 1'b1; AXI_stall = 1'b0;
      ex_valid = 1'b1; ex_opcode = OP_R; ex_rd = 5'd1; ex_data = 32'hDEAD_BEEF;
      ld_issue_valid = 1'b0; ld_issue_opcode = OP_LOAD; ld_issue_funct3 = 3'b010;
      ld_issue_rd = 5'd0; ld_issue_addr_lo = 2'd0;
      ld_rvalid = 1'b0; ld_rdata = '0;
      chk_rs1 = '0; chk_rs2 = '0; chk_rs1_fp = 1'b0; chk_rs2_fp = 1'b0;

      // Reset: ex_valid held high must not be accepted or written.
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst_reg_we", 32'(reg_we), 32'd0);
      chk("rst_ex_ready", 32'(ex_ready), 32'd0);
      chk("rst_w_data", reg_w_data, 32'd0);
      next_cycle();
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      chk("post_rst_reg_we", 32'(reg_we), 32'd0);
      chk("post_rst_issue_ready", 32'(ld_issue_ready), 32'd1);

      // Plain ex result.
      next_cycle();
      ex_valid = 1'b1; ex_opcode = OP_R; ex_rd = 5'd5; ex_data = 32'h1234_5678;
      @(negedge clk);
      chk("ex_ready", 32'(ex_ready), 32'd1);
      chk("ex_ld_rready", 32'(ld_rready), 32'd0);
      expect_wr(5'd5, OP_R, 32'h1234_5678);
      next_cycle();
      clear_inputs();

      // LB byte 2 of 0x0080FF00 -> 0xFFFFFF80.
      issue(OP_LOAD, 3'b000, 5'd7, 2'd2);
      @(negedge clk);
      chk("lb_issue_ready", 32'(ld_issue_ready), 32'd1);
      next_cycle();
      clear_inputs();
      ld_rvalid = 1'b1; ld_rdata = 32'h0080_FF00;
      @(negedge clk);
      chk("lb_rready", 32'(ld_rready), 32'd1);
      expect_wr(5'd7, OP_LOAD, 32'hFFFF_FF80);
      next_cycle();
      clear_inputs();

      // LHU upper half of the same word -> 0x00000080.
      issue(OP_LOAD, 3'b101, 5'd8, 2'd2);
      next_cycle();
      clear_inputs();
      ld_rvalid = 1'b1; ld_rdata = 32'h0080_FF00;
      @(negedge clk);
      chk("lhu_rready", 32'(ld_rready), 32'd1);
      expect_wr(5'd8, OP_LOAD, 32'h0000_0080);
      next_cycle();
      clear_inputs();

      // Fill the FIFO; a third issue is refused even while a pop happens.
      issue(OP_LOAD, 3'b010, 5'd9, 2'd0);
      next_cycle();
      issue(OP_LOAD, 3'b010, 5'd10, 2'd0);
      next_cycle();
      issue(OP_LOAD, 3'b010, 5'd11, 2'd0);
      ld_rvalid = 1'b1; ld_rdata = 32'hAAAA_5555;
      @(negedge clk);
      chk("full_issue_ready", 32'(ld_issue_ready), 32'd0);
      chk("full_pop_rready", 32'(ld_rready), 32'd1);
      expect_wr(5'd9, OP_LOAD, 32'hAAAA_5555);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      chk("after_pop_issue_ready", 32'(ld_issue_ready), 32'd1);
      next_cycle();
      ld_rvalid = 1'b1; ld_rdata = 32'h1111_2222;
      @(negedge clk);
      chk("second_pop_rready", 32'(ld_rready), 32'd1);
      expect_wr(5'd10, OP_LOAD, 32'h1111_2222);
      next_cycle();
      @(negedge clk);
      chk("empty_rready", 32'(ld_rready), 32'd0);
      next_cycle();
      clear_inputs();

      // ex and load data together: ex first, load next cycle.
      issue(OP_LOAD, 3'b010, 5'd12, 2'd0);
      next_cycle();
      clear_inputs();
      ex_valid = 1'b1; ex_opcode = OP_R; ex_rd = 5'd13; ex_data = 32'hCAFE_0001;
      ld_rvalid = 1'b1; ld_rdata = 32'hBEEF_0002;
      @(negedge clk);
      chk("both_ex_ready", 32'(ex_ready), 32'd1);
      chk("both_ld_rready", 32'(ld_rready), 32'd0);
      expect_wr(5'd13, OP_R, 32'hCAFE_0001);
      next_cycle();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("both_ld_second", 32'(ld_rready), 32'd1);
      expect_wr(5'd12, OP_LOAD, 32'hBEEF_0002);
      next_cycle();
      clear_inputs();

      // Stall for 3 cycles with a pending output and competing sources.
      ex_valid = 1'b1; ex_opcode = OP_R; ex_rd = 5'd14; ex_data = 32'h0F0F_0F0F;
      issue(OP_LOAD, 3'b010, 5'd15, 2'd0);
      @(negedge clk);
      chk("stall_pre_ex_ready", 32'(ex_ready), 32'd1);
      expect_wr(5'd14, OP_R, 32'h0F0F_0F0F);
      next_cycle();
      ld_issue_valid = 1'b0;
      AXI_stall = 1'b1;
      ex_rd = 5'd16; ex_data = 32'h1616_1616;
      ld_rvalid = 1'b1; ld_rdata = 32'h1515_1515;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stall_ex_ready", 32'(ex_ready), 32'd0);
         chk("stall_rready", 32'(ld_rready), 32'd0);
         chk("stall_hold_data", reg_w_data, 32'h0F0F_0F0F);
         chk("stall_hold_we", 32'(reg_we), 32'd1);
         next_cycle();
      end
      AXI_stall = 1'b0;
      @(negedge clk);
      chk("unstall_ex_ready", 32'(ex_ready), 32'd1);
      chk("unstall_rready", 32'(ld_rready), 32'd0);
      expect_wr(5'd16, OP_R, 32'h1616_1616);
      next_cycle();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("unstall_ld_rready", 32'(ld_rready), 32'd1);
      expect_wr(5'd15, OP_LOAD, 32'h1515_1515);
      next_cycle();
      clear_inputs();

      // FLW to f3 (funct3/addr_lo ignored), then a load to x0.
      issue(OP_FLW, 3'b000, 5'd3, 2'd1);
      next_cycle();
      issue(OP_LOAD, 3'b000, 5'd0, 2'd0);
      chk_rs1 = 5'd3; chk_rs1_fp = 1'b1;
      chk_rs2 = 5'd3; chk_rs2_fp = 1'b0;
      @(negedge clk);
      chk("haz_flw_fp", 32'(hazard_rs1), 32'(SB_EN));
      chk("haz_flw_int", 32'(hazard_rs2), 32'd0);
      next_cycle();
      clear_inputs();
      chk_rs1 = 5'd0; chk_rs1_fp = 1'b0;
      chk_rs2 = 5'd3; chk_rs2_fp = 1'b1;
      ld_rvalid = 1'b1; ld_rdata = 32'h4049_0FDB;
      @(negedge clk);
      chk("haz_x0", 32'(hazard_rs1), 32'd0);
      chk("haz_flw_rs2", 32'(hazard_rs2), 32'(SB_EN));
      chk("flw_rready", 32'(ld_rready), 32'd1);
      expect_wr(5'd3, OP_FLW, 32'h4049_0FDB);
      next_cycle();
      ld_rdata = 32'h0000_00FF;
      chk_rs1 = 5'd3; chk_rs1_fp = 1'b1;
      @(negedge clk);
      chk("x0_rready", 32'(ld_rready), 32'd1);
      chk("haz_out_stage", 32'(hazard_rs1), 32'(SB_EN));
      next_cycle();
      @(negedge clk);
      chk("x0_reg_we", 32'(reg_we), 32'd0);
      chk("x0_popped", 32'(ld_rready), 32'd0);
      next_cycle();
      clear_inputs();

      // Drain the scoreboard with a bounded wait.
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) next_cycle();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending writes expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
